// File: rtl/ysyx_25030093_xbar.sv
// ysyx_25030093_xbar: AXI4-Lite 1-to-3 router (SRAM/UART/CLINT) with local DECERR for unmapped addresses
// Ports: clk, rst (async active-low); m_* upstream AXI4-Lite slave port;
// s_* downstream master port, per-slave valid/ready bit0 SRAM, bit1 UART, bit2 CLINT,
// packed per-slave data/resp buses, broadcast address/data/strobe.
// Optional: define XBAR_TIMEOUT_EN to abort a stalled slave after TIMEOUT cycles with SLVERR.
module ysyx_25030093_xbar #(
  parameter logic [31:0] SRAM_BASE  = 32'h8000_0000,
  parameter logic [31:0] SRAM_MASK  = 32'hF800_0000,
  parameter logic [31:0] UART_BASE  = 32'hA000_03F8,
  parameter logic [31:0] UART_MASK  = 32'hFFFF_FFF8,
  parameter logic [31:0] CLINT_BASE = 32'hA000_0048,
  parameter logic [31:0] CLINT_MASK = 32'hFFFF_FFF8
`ifdef XBAR_TIMEOUT_EN
  , parameter int TIMEOUT = 255
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] m_araddr,
  input  logic        m_arvalid,
  output logic        m_arready,
  output logic [31:0] m_rdata,
  output logic [1:0]  m_rresp,
  output logic        m_rvalid,
  input  logic        m_rready,
  input  logic [31:0] m_awaddr,
  input  logic        m_awvalid,
  output logic        m_awready,
  input  logic [31:0] m_wdata,
  input  logic [7:0]  m_wstrb,
  input  logic        m_wvalid,
  output logic        m_wready,
  output logic [1:0]  m_bresp,
  output logic        m_bvalid,
  input  logic        m_bready,
  output logic [31:0] s_araddr,
  output logic [2:0]  s_arvalid,
  input  logic [2:0]  s_arready,
  input  logic [95:0] s_rdata,
  input  logic [5:0]  s_rresp,
  input  logic [2:0]  s_rvalid,
  output logic [2:0]  s_rready,
  output logic [31:0] s_awaddr,
  output logic [31:0] s_wdata,
  output logic [7:0]  s_wstrb,
  output logic [2:0]  s_awvalid,
  input  logic [2:0]  s_awready,
  output logic [2:0]  s_wvalid,
  input  logic [2:0]  s_wready,
  input  logic [5:0]  s_bresp,
  input  logic [2:0]  s_bvalid,
  output logic [2:0]  s_bready
);
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, RD_RSP, WR_REQ, WR_WAIT, WR_RSP} state_e;
  state_e      state_q, state_d;
  logic [2:0]  sel_q, sel_d;
  logic [31:0] araddr_q, araddr_d, awaddr_q, awaddr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [7:0]  wstrb_q, wstrb_d;
  logic [1:0]  rresp_q, rresp_d, bresp_q, bresp_d;
  logic        aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic        ar_go, w_go, to, ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic [2:0]  ar_sel, w_sel;
  logic [31:0] sel_rdata;
  logic [1:0]  sel_rresp, sel_bresp;
  function automatic logic [2:0] dec(input logic [31:0] a);
    return ((a & SRAM_MASK) == SRAM_BASE) ? 3'b001 :
           ((a & UART_MASK) == UART_BASE) ? 3'b010 :
           ((a & CLINT_MASK) == CLINT_BASE) ? 3'b100 : 3'b000;
  endfunction
`ifdef XBAR_TIMEOUT_EN
  logic [31:0] cnt_q;
  // REQ states are only entered from IDLE, so clearing in IDLE clears on entry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else cnt_q <= (state_q == IDLE) ? '0 : cnt_q + 32'd1;
  end
  assign to = (state_q == RD_REQ || state_q == RD_WAIT || state_q == WR_REQ || state_q == WR_WAIT)
              && cnt_q == 32'(TIMEOUT);
`else
  assign to = 1'b0;
`endif
  assign ar_sel = dec(m_araddr);
  assign w_sel  = dec(m_awaddr);
  assign ar_go  = state_q == IDLE && m_arvalid;
  assign w_go   = state_q == IDLE && m_awvalid && m_wvalid && !m_arvalid;
  // readies are gated by rst so every handshake output reads 0 while in reset
  assign m_arready = rst && state_q == IDLE;
  assign m_awready = rst && w_go;
  assign m_wready  = rst && w_go;
  assign m_rvalid  = state_q == RD_RSP;
  assign m_bvalid  = state_q == WR_RSP;
  assign m_rdata   = rdata_q;
  assign m_rresp   = rresp_q;
  assign m_bresp   = bresp_q;
  assign s_araddr  = araddr_q;
  assign s_awaddr  = awaddr_q;
  assign s_wdata   = wdata_q;
  assign s_wstrb   = wstrb_q;
  assign s_arvalid = (state_q == RD_REQ && !to) ? sel_q : 3'b000;
  assign s_rready  = (state_q == RD_WAIT && !to) ? sel_q : 3'b000;
  assign s_awvalid = (state_q == WR_REQ && !aw_done_q && !to) ? sel_q : 3'b000;
  assign s_wvalid  = (state_q == WR_REQ && !w_done_q && !to) ? sel_q : 3'b000;
  assign s_bready  = (state_q == WR_WAIT && !to) ? sel_q : 3'b000;
  assign ar_hs = |(s_arvalid & s_arready);
  assign r_hs  = |(s_rready & s_rvalid);
  assign aw_hs = |(s_awvalid & s_awready);
  assign w_hs  = |(s_wvalid & s_wready);
  assign b_hs  = |(s_bready & s_bvalid);
  always_comb begin
    sel_rdata = '0;
    sel_rresp = '0;
    sel_bresp = '0;
    for (int i = 0; i < 3; i++) begin
      sel_rdata = sel_rdata | (sel_q[i] ? s_rdata[32*i +: 32] : 32'd0);
      sel_rresp = sel_rresp | (sel_q[i] ? s_rresp[2*i +: 2] : 2'd0);
      sel_bresp = sel_bresp | (sel_q[i] ? s_bresp[2*i +: 2] : 2'd0);
    end
  end
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    araddr_d  = araddr_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    bresp_d   = bresp_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      IDLE: begin
        if (ar_go) begin
          sel_d    = ar_sel;
          araddr_d = m_araddr;
          state_d  = |ar_sel ? RD_REQ : RD_RSP;
          rresp_d  = |ar_sel ? rresp_q : 2'b11;
          rdata_d  = |ar_sel ? rdata_q : 32'd0;
        end else if (w_go) begin
          sel_d     = w_sel;
          awaddr_d  = m_awaddr;
          wdata_d   = m_wdata;
          wstrb_d   = m_wstrb;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = |w_sel ? WR_REQ : WR_RSP;
          bresp_d   = |w_sel ? bresp_q : 2'b11;
        end
      end
      RD_REQ: begin
        state_d = to ? RD_RSP : ar_hs ? RD_WAIT : RD_REQ;
        rresp_d = to ? 2'b10 : rresp_q;
        rdata_d = to ? 32'd0 : rdata_q;
      end
      RD_WAIT: begin
        state_d = (to || r_hs) ? RD_RSP : RD_WAIT;
        rresp_d = to ? 2'b10 : r_hs ? sel_rresp : rresp_q;
        rdata_d = to ? 32'd0 : r_hs ? sel_rdata : rdata_q;
      end
      RD_RSP: state_d = m_rready ? IDLE : RD_RSP;
      WR_REQ: begin
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        state_d   = to ? WR_RSP : (aw_done_d && w_done_d) ? WR_WAIT : WR_REQ;
        bresp_d   = to ? 2'b10 : bresp_q;
      end
      WR_WAIT: begin
        state_d = (to || b_hs) ? WR_RSP : WR_WAIT;
        bresp_d = to ? 2'b10 : b_hs ? sel_bresp : bresp_q;
      end
      WR_RSP: state_d = m_bready ? IDLE : WR_RSP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      araddr_q  <= '0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      bresp_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      araddr_q  <= araddr_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      bresp_q   <= bresp_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end
endmodule
